sram_arbiter: RTL and testbench

Two-port arbiter and timing sequencer for the 68k work RAM: one 16-bit word built from a pair of 32K×8 asynchronous 120 ns SRAMs, upper byte on D[15:8] and lower byte on D[7:0]. It accepts word/byte read and write requests from two requesters, port A (CPU side) and port B (loader/DMA side), and grants them round-robin. It generates the chip strobes with cycle-counted setup, pulse and hold phases at 24 MHz, and returns read data with a one-cycle acknowledge.

---
 rtl/sram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter and strobe sequencer for one 16-bit
// word of asynchronous SRAM built from two x8 chips sharing address, nCE and nOE.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no access in flight, arbitrate between A_REQ and B_REQ
// READ     | nCE/nOE low, word captured when the counter reaches 0
// WR_SETUP | address and write data driven, both nWE high
// WR_PULSE | nWEU/nWEL low per byte enable for WRITE_CYCLES cycles
// WR_HOLD  | nWE high, nCE/address/data still driven
// DONE     | all strobes high, bus released, ACK to the granted port

module sram_arbiter #(
  parameter int READ_CYCLES  = 4,
  parameter int WRITE_CYCLES = 3
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [14:0] A_ADDR,
  input  logic [1:0]  A_BE,
  input  logic [15:0] A_WDATA,
  output logic [15:0] A_RDATA,
  output logic        A_ACK,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [14:0] B_ADDR,
  input  logic [1:0]  B_BE,
  input  logic [15:0] B_WDATA,
  output logic [15:0] B_RDATA,
  output logic        B_ACK,
  output logic [14:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DATA,
  output logic        SRAM_nCE,
  output logic        SRAM_nOE,
  output logic        SRAM_nWEU,
  output logic        SRAM_nWEL,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        port_b_q, port_b_d;
  logic        last_b_q, last_b_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        nce_q, nce_d;
  logic        noe_q, noe_d;
  logic        nweu_q, nweu_d;
  logic        nwel_q, nwel_d;
  logic        data_oe_q, data_oe_d;
  logic        grant_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_b_d  = port_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    // B wins only when A is absent or A was the last port served
    grant_b   = B_REQ && (!A_REQ || !last_b_q);

    case (state_q)
      S_IDLE: begin
        if (A_REQ || B_REQ) begin
          port_b_d = grant_b;
          last_b_d = grant_b;
          we_d     = grant_b ? B_WE    : A_WE;
          addr_d   = grant_b ? B_ADDR  : A_ADDR;
          be_d     = grant_b ? B_BE    : A_BE;
          wdata_d  = grant_b ? B_WDATA : A_WDATA;
          cnt_d    = RD_LOAD;
          state_d  = we_d ? S_WR_SETUP : S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          if (port_b_q) b_rdata_d = SRAM_DATA;
          else          a_rdata_d = SRAM_DATA;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave flops directly.
    nce_d     = !(state_d inside {S_READ, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    noe_d     = (state_d != S_READ);
    nweu_d    = !((state_d == S_WR_PULSE) && be_d[1]);
    nwel_d    = !((state_d == S_WR_PULSE) && be_d[0]);
    data_oe_d = state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    a_ack_d   = (state_d == S_DONE) && !port_b_d;
    b_ack_d   = (state_d == S_DONE) &&  port_b_d;
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      port_b_q  <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 15'd0;
      be_q      <= 2'b00;
      wdata_q   <= 16'd0;
      a_rdata_q <= 16'd0;
      b_rdata_q <= 16'd0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      nce_q     <= 1'b1;
      noe_q     <= 1'b1;
      nweu_q    <= 1'b1;
      nwel_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_b_q  <= port_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      nce_q     <= nce_d;
      noe_q     <= noe_d;
      nweu_q    <= nweu_d;
      nwel_q    <= nwel_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign SRAM_DATA = data_oe_q ? wdata_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_nCE  = nce_q;
  assign SRAM_nOE  = noe_q;
  assign SRAM_nWEU = nweu_q;
  assign SRAM_nWEL = nwel_q;
  assign A_RDATA   = a_rdata_q;
  assign B_RDATA   = b_rdata_q;
  assign A_ACK     = a_ack_q;
  assign B_ACK     = b_ack_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM chip model on the bus, a word-level reference
// memory plus round-robin model, directed scenarios and a randomized phase.

module tb_sram_arbiter;
  localparam int RC = 4;
  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [1:0]  a_be, b_be;
  logic [15:0] a_wdata, b_wdata;
  logic [15:0] a_rdata, b_rdata;
  logic        a_ack, b_ack;
  logic [14:0] sram_addr;
  tri1  [15:0] sram_data;
  logic        nce, noe, nweu, nwel, busy;

  always #21 clk = ~clk;

  sram_arbiter #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .CLK_24M(clk), .RESET(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_BE(a_be), .A_WDATA(a_wdata),
    .A_RDATA(a_rdata), .A_ACK(a_ack),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_BE(b_be), .B_WDATA(b_wdata),
    .B_RDATA(b_rdata), .B_ACK(b_ack),
    .SRAM_ADDR(sram_addr), .SRAM_DATA(sram_data), .SRAM_nCE(nce), .SRAM_nOE(noe),
    .SRAM_nWEU(nweu), .SRAM_nWEL(nwel), .BUSY(busy)
  );

  // Asynchronous SRAM pair: drives the bus while selected and output-enabled,
  // latches each byte on the rising edge of its write strobe.
  logic [15:0] sram_mem [0:32767];
  assign sram_data = (!nce && !noe) ? sram_mem[sram_addr] : 16'hzzzz;
  always @(posedge nweu) if (!nce) sram_mem[sram_addr][15:8] = sram_data[15:8];
  always @(posedge nwel) if (!nce) sram_mem[sram_addr][7:0]  = sram_data[7:0];

  logic [15:0] ref_mem [int];
  bit          ref_last_b;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  task automatic model_apply(input bit we, input logic [14:0] addr, input logic [1:0] be,
                             input logic [15:0] wd, input logic [15:0] rd, input string tag);
    int key = int'(addr);
    if (we) ref_mem[key] = merge(ref_mem.exists(key) ? ref_mem[key] : 16'h0000, wd, be);
    else if (ref_mem.exists(key)) chk(tag, rd, ref_mem[key]);
  endtask

  // Bus invariants and read-data stability, sampled mid-cycle.
  logic [15:0] prev_a, prev_b;
  always @(negedge clk) begin
    if (rst) begin
      prev_a = a_rdata;
      prev_b = b_rdata;
    end else begin
      chk("oe_we_overlap", !noe && (!nweu || !nwel), 1'b0);
      chk("oe_without_ce", !noe && nce, 1'b0);
      chk("ack_overlap", a_ack && b_ack, 1'b0);
      if (nce) chk("bus_released", sram_data, 16'hFFFF);
      if (!a_ack) chk("a_rdata_stable", a_rdata, prev_a);
      if (!b_ack) chk("b_rdata_stable", b_rdata, prev_b);
      prev_a = a_rdata;
      prev_b = b_rdata;
    end
  end

  task automatic drive(input bit pb, input bit we, input logic [14:0] addr,
                       input logic [1:0] be, input logic [15:0] wd);
    if (pb) begin b_we = we; b_addr = addr; b_be = be; b_wdata = wd; b_req = 1'b1; end
    else    begin a_we = we; a_addr = addr; a_be = be; a_wdata = wd; a_req = 1'b1; end
  endtask

  // One access from a single port; called #1 after a rising edge.
  task automatic do_access(input bit pb, input bit we, input logic [14:0] addr,
                           input logic [1:0] be, input logic [15:0] wd, input string tag);
    int lat = 0, nu = 0, nl = 0;
    bit granted = 0, acked = 0;
    logic [15:0] rd, rd_before;
    rd_before = pb ? b_rdata : a_rdata;
    drive(pb, we, addr, be, wd);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin granted = 1; break; end
    end
    chk({tag, "_grant"}, granted, 1'b1);
    // Inputs are don't-care once granted.
    if (pb) begin b_addr = 15'($urandom); b_wdata = 16'($urandom); b_be = 2'($urandom); b_we = !we; end
    else    begin a_addr = 15'($urandom); a_wdata = 16'($urandom); a_be = 2'($urandom); a_we = !we; end
    for (int i = 0; i < 40 && granted; i++) begin
      @(posedge clk); #1;
      lat++;
      if (!nweu) nu++;
      if (!nwel) nl++;
      if (pb ? b_ack : a_ack) begin acked = 1; break; end
    end
    if (pb) b_req = 1'b0; else a_req = 1'b0;
    rd = pb ? b_rdata : a_rdata;
    chk({tag, "_ack"}, acked, 1'b1);
    chk({tag, "_latency"}, lat, we ? WC + 2 : RC);
    if (we) begin
      chk({tag, "_nweu_cycles"}, nu, be[1] ? WC : 0);
      chk({tag, "_nwel_cycles"}, nl, be[0] ? WC : 0);
      chk({tag, "_rdata_kept"}, rd, rd_before);
    end
    model_apply(we, addr, be, wd, rd, {tag, "_rdata"});
    ref_last_b = pb;
  endtask

  // Both ports request in the same cycle; order predicted from the round-robin rule.
  task automatic both_round(input bit wa, input logic [14:0] aa, input logic [1:0] bea,
                            input logic [15:0] wda, input bit wb, input logic [14:0] ab,
                            input logic [1:0] beb, input logic [15:0] wdb, input string tag);
    bit exp_b_first = !ref_last_b;
    bit got_a = 0, got_b = 0, first_b = 0;
    logic [15:0] rda = 16'h0, rdb = 16'h0;
    drive(1'b0, wa, aa, bea, wda);
    drive(1'b1, wb, ab, beb, wdb);
    for (int i = 0; i < 80 && !(got_a && got_b); i++) begin
      @(posedge clk); #1;
      if (a_ack && !got_a) begin got_a = 1; a_req = 1'b0; rda = a_rdata; if (!got_b) first_b = 0; end
      if (b_ack && !got_b) begin got_b = 1; b_req = 1'b0; rdb = b_rdata; if (!got_a) first_b = 1; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk({tag, "_both_acked"}, got_a && got_b, 1'b1);
    chk({tag, "_order_b_first"}, first_b, exp_b_first);
    if (exp_b_first) begin
      model_apply(wb, ab, beb, wdb, rdb, {tag, "_b_rdata"});
      model_apply(wa, aa, bea, wda, rda, {tag, "_a_rdata"});
    end else begin
      model_apply(wa, aa, bea, wda, rda, {tag, "_a_rdata"});
      model_apply(wb, ab, beb, wdb, rdb, {tag, "_b_rdata"});
    end
    ref_last_b = !exp_b_first;
  endtask

  logic [14:0] pool [4] = '{15'h0100, 15'h0200, 15'h3FFF, 15'h5555};

  initial begin
    #(42 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, a_acks;
    bit          seq [3];
    logic [15:0] b_rd;
    bit          reached;

    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_be = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_be = 0; b_wdata = 0;
    ref_last_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nce", nce, 1'b1);
    chk("rst_noe", noe, 1'b1);
    chk("rst_nwe", {nweu, nwel}, 2'b11);
    chk("rst_addr", sram_addr, 15'h0);
    chk("rst_bus", sram_data, 16'hFFFF);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    chk("rst_ack_busy", {a_ack, b_ack, busy}, 3'b000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    do_access(0, 1, 15'h0010, 2'b11, 16'h1234, "a_wr");
    do_access(0, 0, 15'h0010, 2'b00, 16'h0000, "a_rd");

    do_access(0, 1, 15'h7FFF, 2'b11, 16'hFFFF, "preload");
    do_access(1, 1, 15'h7FFF, 2'b01, 16'hAB55, "b_wr_lo");
    do_access(1, 0, 15'h7FFF, 2'b00, 16'h0000, "b_rd_lo");
    do_access(1, 1, 15'h7FFF, 2'b00, 16'h1234, "b_wr_none");
    do_access(1, 0, 15'h7FFF, 2'b11, 16'h0000, "b_rd_none");

    both_round(0, 15'h0010, 2'b11, 16'h0, 0, 15'h7FFF, 2'b11, 16'h0, "arb1");
    both_round(1, 15'h0020, 2'b10, 16'hC3A5, 0, 15'h0010, 2'b11, 16'h0, "arb2");

    // A keeps REQ high through its ACK while B requests once.
    drive(0, 1, 15'h0444, 2'b11, 16'h5A5A);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin reached = 1; break; end
    end
    chk("hold_grant", reached, 1'b1);
    drive(1, 0, 15'h0444, 2'b11, 16'h0);
    n = 0; a_acks = 0; b_rd = 16'h0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(posedge clk); #1;
      if (a_ack) begin
        if (n < 3) seq[n] = 0;
        n++; a_acks++;
        if (a_acks == 2) a_req = 1'b0;
      end
      if (b_ack) begin
        if (n < 3) seq[n] = 1;
        n++; b_req = 1'b0; b_rd = b_rdata;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("hold_acks", n, 3);
    chk("hold_order", {seq[0], seq[1], seq[2]}, 3'b010);
    chk("hold_b_rdata", b_rd, 16'h5A5A);
    ref_mem[int'(15'h0444)] = 16'h5A5A;
    ref_last_b = 1'b0;

    // Reset in the middle of the write pulse.
    drive(0, 1, 15'h0999, 2'b11, 16'h0F0F);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!nwel) begin reached = 1; break; end
    end
    chk("rst_mid_pulse_reached", reached, 1'b1);
    #5 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {nce, noe, nweu, nwel}, 4'hF);
    chk("rst_mid_bus", sram_data, 16'hFFFF);
    chk("rst_mid_busy_ack", {busy, a_ack, b_ack}, 3'b000);
    chk("rst_mid_rdata", {a_rdata, b_rdata}, 32'h0);
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_ack", {a_ack, b_ack}, 2'b00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    ref_mem.delete(int'(15'h0999));
    ref_last_b = 1'b1;
    do_access(1, 1, 15'h0999, 2'b11, 16'h7E81, "post_rst_wr");
    do_access(0, 0, 15'h0999, 2'b11, 16'h0, "post_rst_rd");
    do_access(0, 0, 15'h0010, 2'b11, 16'h0, "post_rst_old");

    for (int i = 0; i < 4; i++) do_access(0, 1, pool[i], 2'b11, 16'($urandom), "pool_init");
    for (int it = 0; it < 30; it++) begin
      int mode = int'($urandom_range(0, 2));
      bit w0 = 1'($urandom), w1 = 1'($urandom);
      logic [14:0] ad0 = pool[$urandom_range(0, 3)], ad1 = pool[$urandom_range(0, 3)];
      logic [1:0] be0 = 2'($urandom), be1 = 2'($urandom);
      logic [15:0] d0 = 16'($urandom), d1 = 16'($urandom);
      if (mode == 0)      do_access(0, w0, ad0, be0, d0, "rnd_a");
      else if (mode == 1) do_access(1, w0, ad0, be0, d0, "rnd_b");
      else                both_round(w0, ad0, be0, d0, w1, ad1, be1, d1, "rnd_ab");
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
